// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack for nested interrupts.
// Optional build macro PC_STACK_FAULT_VECTOR_EN redirects overflow/underflow to FAULT_VEC.
module pc_stack_unit #(
  parameter int unsigned    AW        = 16,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [AW-1:0]  RESET_VEC = '0,
  parameter int unsigned    STEP      = 1,
  parameter logic [AW-1:0]  FAULT_VEC = AW'('hFFF0)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_set_enable,
  input  logic [AW-1:0]              i_set_address,
  input  logic                       i_irq_enable,
  input  logic [AW-1:0]              i_irq_address,
  input  logic                       i_ret_enable,
  input  logic                       i_lock,
  input  logic                       i_address_en,
  output logic [AW-1:0]              o_address,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_fault
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef PC_STACK_FAULT_VECTOR_EN
  localparam bit FAULT_REDIRECT = 1'b1;
`else
  localparam bit FAULT_REDIRECT = 1'b0;
`endif

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          fault_q, fault_d;
  logic [AW-1:0] stack_q [DEPTH];

  logic          full, empty;
  logic          push, pop, bad_req;
  logic [IW-1:0] wr_idx, rd_idx;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  // An irq always shadows a simultaneous ret, even when the irq itself overflows.
  assign push    = i_irq_enable && !full;
  assign pop     = i_ret_enable && !i_irq_enable && !empty;
  assign bad_req = (i_irq_enable && full) || (i_ret_enable && !i_irq_enable && empty);
  assign wr_idx  = depth_q[IW-1:0];
  assign rd_idx  = IW'(depth_q - DW'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q | bad_req;
    if (push) begin
      pc_d    = i_irq_address;
      depth_d = depth_q + DW'(1);
    end else if (pop) begin
      pc_d    = stack_q[rd_idx];
      depth_d = depth_q - DW'(1);
    end else if (FAULT_REDIRECT && bad_req) begin
      pc_d = FAULT_VEC;
    end else if (i_set_enable) begin
      pc_d = i_set_address;
    end else if (!i_lock) begin
      pc_d = pc_q + AW'(STEP);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: stack storage has no reset; entries are only read below depth_q, which reset clears.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[wr_idx] <= pc_q;
    end
  end

  assign o_address = i_address_en ? pc_q : '0;
  assign o_depth   = depth_q;
  assign o_full    = full;
  assign o_empty   = empty;
  assign o_fault   = fault_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int DEPTH = 4;
  localparam logic [15:0] FAULT_VEC = 16'hFFF0;
`ifdef PC_STACK_FAULT_VECTOR_EN
  localparam bit FV_EN = 1'b1;
`else
  localparam bit FV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_set_enable, i_irq_enable, i_ret_enable, i_lock, i_address_en;
  logic [15:0] i_set_address, i_irq_address;
  logic [15:0] o_address;
  logic [2:0]  o_depth;
  logic        o_full, o_empty, o_fault;

  pc_stack_unit dut (
    .clk(clk), .n_rst(n_rst),
    .i_set_enable(i_set_enable), .i_set_address(i_set_address),
    .i_irq_enable(i_irq_enable), .i_irq_address(i_irq_address),
    .i_ret_enable(i_ret_enable), .i_lock(i_lock), .i_address_en(i_address_en),
    .o_address(o_address), .o_depth(o_depth), .o_full(o_full),
    .o_empty(o_empty), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PC, return stack as a queue, sticky fault.
  logic [15:0] exp_pc;
  logic [15:0] stk[$];
  logic        exp_fault;

  wire [21:0] status = {o_address, o_depth, o_full, o_empty, o_fault};

  function automatic logic [21:0] exp_status();
    logic [15:0] a;
    a = i_address_en ? exp_pc : 16'h0000;
    return {a, 3'(stk.size()), stk.size() == DEPTH, stk.size() == 0, exp_fault};
  endfunction

  task automatic model_reset();
    exp_pc    = 16'h0000;
    stk.delete();
    exp_fault = 1'b0;
  endtask

  task automatic model_step(input logic irq, input logic [15:0] ia, input logic ret,
                            input logic set, input logic [15:0] sa, input logic lock);
    bit taken = 0;
    bit flt   = 0;
    if (irq) begin
      if (stk.size() < DEPTH) begin
        stk.push_back(exp_pc);
        exp_pc = ia;
        taken  = 1;
      end else flt = 1;
    end else if (ret) begin
      if (stk.size() > 0) begin
        exp_pc = stk.pop_back();
        taken  = 1;
      end else flt = 1;
    end
    if (!taken) begin
      if (flt && FV_EN) exp_pc = FAULT_VEC;
      else if (set)     exp_pc = sa;
      else if (!lock)   exp_pc = exp_pc + 16'd1;
    end
    if (flt) exp_fault = 1'b1;
  endtask

  // Drives one clock cycle from a negedge and returns at the following negedge.
  task automatic cycle(input logic irq, input logic [15:0] ia, input logic ret,
                       input logic set, input logic [15:0] sa, input logic lock);
    i_irq_enable = irq; i_irq_address = ia; i_ret_enable = ret;
    i_set_enable = set; i_set_address = sa; i_lock = lock;
    @(posedge clk);
    model_step(irq, ia, ret, set, sa, lock);
    @(negedge clk);
    i_irq_enable = 1'b0; i_ret_enable = 1'b0; i_set_enable = 1'b0; i_lock = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    i_set_enable = 0; i_irq_enable = 0; i_ret_enable = 0; i_lock = 0;
    i_set_address = '0; i_irq_address = '0; i_address_en = 1'b1;
    model_reset();
    #3;
    total++;
    if (status !== 22'({16'h0000, 3'd0, 1'b0, 1'b1, 1'b0})) begin
      bad++; $display("FAIL reset_state actual=%h required=%h", status, {16'h0000, 3'd0, 3'b010});
    end
    i_address_en = 1'b0;
    #1;
    total++;
    if (o_address !== 16'h0000) begin
      bad++; $display("FAIL reset_addr_disabled actual=%h required=0000", o_address);
    end
    i_address_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (o_address !== 16'(i) || o_empty !== 1'b1) begin
        bad++; $display("FAIL free_run%0d actual=%h empty=%b required=%h empty=1", i, o_address, o_empty, 16'(i));
      end
      cycle(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_irq_ret();
    cycle(0, 0, 0, 1, 16'h0010, 0);
    cycle(1, 16'h0100, 0, 0, 0, 0);
    total++;
    if (o_address !== 16'h0100 || o_depth !== 3'd1) begin
      bad++; $display("FAIL irq_entry actual=%h/%0d required=0100/1", o_address, o_depth);
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    total++;
    if (o_address !== 16'h0102) begin
      bad++; $display("FAIL handler_run actual=%h required=0102", o_address);
    end
    cycle(0, 0, 1, 0, 0, 0);
    total++;
    if (o_address !== 16'h0010 || o_depth !== 3'd0 || status !== exp_status()) begin
      bad++; $display("FAIL irq_return actual=%h required=%h", status, exp_status());
    end
  endtask

  task automatic test_nested();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 1, 16'h0020 + 16'(k * 16), 0);
      cycle(1, 16'h1000 + 16'(k * 256), 0, 0, 0, 0);
      total++;
      if (o_depth !== 3'(k + 1) || o_full !== (k == 3) || status !== exp_status()) begin
        bad++; $display("FAIL nest_push%0d actual=%h required=%h", k, status, exp_status());
      end
    end
    for (int k = 3; k >= 0; k--) begin
      cycle(0, 0, 1, 0, 0, 0);
      total++;
      if (o_address !== 16'h0020 + 16'(k * 16) || o_depth !== 3'(k)) begin
        bad++; $display("FAIL nest_pop%0d actual=%h/%0d required=%h/%0d", k, o_address, o_depth, 16'h0020 + 16'(k * 16), k);
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) cycle(1, 16'($urandom), 0, 0, 0, 0);
    cycle(1, 16'h0777, 0, 1, 16'h0200, 0);
    total++;
    if (o_fault !== 1'b1 || o_depth !== 3'd4 || o_address !== (FV_EN ? 16'hFFF0 : 16'h0200)) begin
      bad++; $display("FAIL overflow actual=%h/%0d/%b required=%h/4/1", o_address, o_depth, o_fault, FV_EN ? 16'hFFF0 : 16'h0200);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 0, 0);
    total++;
    if (status !== exp_status()) begin
      bad++; $display("FAIL overflow_unwind actual=%h required=%h", status, exp_status());
    end
  endtask

  task automatic test_underflow_and_corners();
    do_reset();
    cycle(0, 0, 1, 0, 0, 1);
    total++;
    if (o_fault !== 1'b1 || o_depth !== 3'd0 || o_address !== (FV_EN ? 16'hFFF0 : 16'h0000)) begin
      bad++; $display("FAIL underflow actual=%h/%0d/%b required=%h/0/1", o_address, o_depth, o_fault, FV_EN ? 16'hFFF0 : 16'h0000);
    end
    cycle(1, 16'h0300, 1, 0, 0, 0);
    total++;
    if (o_address !== 16'h0300 || o_depth !== 3'd1 || status !== exp_status()) begin
      bad++; $display("FAIL irq_ret_same actual=%h required=%h", status, exp_status());
    end
    cycle(0, 0, 0, 1, 16'hFFFF, 0);
    cycle(0, 0, 0, 0, 0, 0);
    total++;
    if (o_address !== 16'h0000) begin
      bad++; $display("FAIL pc_wrap actual=%h required=0000", o_address);
    end
    cycle(0, 0, 0, 0, 0, 1);
    total++;
    if (o_address !== 16'h0000) begin
      bad++; $display("FAIL lock_hold actual=%h required=0000", o_address);
    end
  endtask

  task automatic test_reset_mid_nest();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 16'h0400 + 16'(k), 0, 0, 0, 0);
    total++;
    if (o_depth !== 3'd3 || o_fault !== 1'b1) begin
      bad++; $display("FAIL pre_reset_nest actual=%0d/%b required=3/1", o_depth, o_fault);
    end
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (status !== 22'({16'h0000, 3'd0, 1'b0, 1'b1, 1'b0})) begin
      bad++; $display("FAIL async_reset actual=%h required=%h", status, {16'h0000, 3'd0, 3'b010});
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_random();
    logic irq, ret, set, lock;
    for (int n = 0; n < 400; n++) begin
      irq  = ($urandom_range(0, 99) < 20);
      ret  = ($urandom_range(0, 99) < 22);
      set  = ($urandom_range(0, 99) < 25);
      lock = ($urandom_range(0, 99) < 20);
      i_address_en = ($urandom_range(0, 9) != 0);
      cycle(irq, 16'($urandom), ret, set, 16'($urandom), lock);
      total++;
      if (status !== exp_status()) begin
        bad++; $display("FAIL random%0d actual=%h required=%h", n, status, exp_status());
      end
      if (n == 200) do_reset();
    end
    i_address_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_irq_ret();
    test_nested();
    test_overflow();
    test_underflow_and_corners();
    test_reset_mid_nest();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
